fp_divider: RTL and testbench
=============================

FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: operands valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-005 SHALL have port Operando_A, input, 32 bits: IEEE-754 single dividend.
REQ-006 SHALL have port Operando_B, input, 32 bits: IEEE-754 single divisor.
REQ-007 SHALL have port out_valid, output, 1 bit: result valid.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer takes result.
REQ-009 SHALL have port Resultado, output, 32 bits: quotient A/B.
REQ-010 SHALL have port Div_cero, output, 1 bit: finite nonzero A divided by zero B; valid with out_valid.

Function
REQ-011 SHALL use FSM states IDLE, DIVIDE, NORM, DONE; in_ready=1 only in IDLE and rst=0.
REQ-012 SHALL accept on rising edge with in_valid=1 and in_ready=1, register both operands, and go IDLE->DIVIDE.
REQ-013 SHALL compute sign = A[31] XOR B[31] for all results, including zero, inf and special cases.
REQ-014 SHALL compute biased exponent as a 10-bit signed value: EA - EB + 127 (the inverse of the multiplier exponent add).
REQ-015 SHALL perform restoring radix-2 division of {1,fracA} by {1,fracB}, 24 bits each, producing one quotient bit per cycle for 26 cycles in DIVIDE.
REQ-016 SHALL in NORM (1 cycle): if quotient MSB=0, shift left 1 and decrement exponent; then apply rounding (REQ-027/028).
REQ-017 SHALL assert out_valid exactly 28 rising edges after the accept edge, independent of operand values, special cases included.
REQ-018 SHALL hold Resultado, Div_cero and out_valid stable in DONE until out_ready=1; on that edge go to DONE->IDLE, out_valid=0, in_ready=1 next cycle.
REQ-019 SHALL ignore in_valid outside IDLE; no queuing.
REQ-020 SHALL flush subnormal inputs (exponent 0) to signed zero; outputs are never subnormal.
REQ-021 SHALL produce, on final exponent >=255, signed infinity (exp 0xFF, frac 0).
REQ-022 SHALL produce, on final exponent <=0, signed zero.
REQ-023 SHALL handle special cases: either NaN, 0/0 or inf/inf -> 0x7FC00000; inf/finite -> signed inf; finite/inf -> signed zero; 0/nonzero -> signed zero; nonzero finite/0 -> signed inf with Div_cero=1.
REQ-024 SHALL drive Div_cero=0 for every case not listed as divide-by-zero in REQ-023.

Reset
REQ-025 SHALL on rst=1 at an edge set state=IDLE, out_valid=0, Resultado=0x00000000 and Div_cero=0, holding in_ready=0 while rst=1.
REQ-026 SHALL, on reset mid-operation (DIVIDE/NORM/DONE), discard the operation with no out_valid pulse and set in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, with macro FP_DIV_RNE_EN defined, round to nearest even using guard bit and sticky (remaining quotient bit OR remainder!=0); a mantissa carry increments the exponent and SHALL overflow to inf per REQ-021.
REQ-028 SHALL, without FP_DIV_RNE_EN, truncate (round toward zero); latency is identical in both builds.

Verification
REQ-029 SHALL test 0x40C00000 / 0x40000000, which SHALL give 0x40400000 with Div_cero=0 and out_valid 28 edges after accept.
REQ-030 SHALL test 0x3F800000 / 0x40400000, which SHALL give 0x3EAAAAAB with FP_DIV_RNE_EN and 0x3EAAAAAA without.
REQ-031 SHALL test 0xBF800000 / 0x00000000, which SHALL give 0xFF800000 with Div_cero=1; and 0x00000000 / 0x00000000, which SHALL give 0x7FC00000 with Div_cero=0.
REQ-032 SHALL test 0x7F000000 / 0x3E800000, which SHALL give 0x7F800000; and 0x00800000 / 0x4B000000, which SHALL give 0x00000000.
REQ-033 SHALL test out_ready held 0 for 5 cycles after out_valid: Resultado stays stable and in_ready stays 0; out_ready=1 returns to IDLE next cycle.
REQ-034 SHALL test rst pulsed 10 cycles after accept: no out_valid pulse, Resultado=0, and a new operation is accepted on the first post-reset cycle.

Source files
------------

// File: rtl/fp_divider.sv
// -----------------------------------------------------------------------------
// fp_divider -- multi-cycle IEEE-754 single-precision divider (Resultado = A / B)
//
// Purpose:
//   Accepts one operand pair per handshake and produces the quotient 28 clock
//   edges after the accept edge, whatever the operand values are. The mantissas
//   are divided by a restoring radix-2 divider that produces one quotient bit
//   per cycle. Subnormal inputs are flushed to signed zero, and results are
//   never subnormal.
//
// Ports:
//   clk         in   1  single clock, rising edge
//   rst         in   1  synchronous active-high reset
//   in_valid    in   1  operands valid
//   in_ready    out  1  block can accept operands (IDLE and not in reset)
//   Operando_A  in  32  dividend (IEEE-754 single)
//   Operando_B  in  32  divisor  (IEEE-754 single)
//   out_valid   out  1  result valid, held until out_ready
//   out_ready   in   1  consumer takes result
//   Resultado   out 32  quotient A / B
//   Div_cero    out  1  finite nonzero A divided by zero B
//
// Configuration:
//   FP_DIV_RNE_EN  defined   -> round to nearest even (guard + sticky)
//                  undefined -> truncate (round toward zero)
//   Latency is the same in both builds.
// -----------------------------------------------------------------------------
module fp_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Operando_A,
  input  logic [31:0] Operando_B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Resultado,
  output logic        Div_cero
);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t             state_q;
  logic [31:0]        a_q, b_q;
  logic [4:0]         cnt_q;
  logic signed [9:0]  exp_q;
  logic [24:0]        rem_q;
  logic [25:0]        quo_q;
  logic [31:0]        res_q;
  logic               dz_q;
  logic               valid_q;

  // Operand fields
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        sign;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign ea   = a_q[30:23];
  assign eb   = b_q[30:23];
  assign fa   = a_q[22:0];
  assign fb   = b_q[22:0];
  assign sign = a_q[31] ^ b_q[31];

  // Exponent 0 covers both true zero and subnormals (flushed to zero).
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

  // ---------------------------------------------------------------------------
  // Restoring divide step. The partial remainder always stays below 2*{1,fb},
  // so 25 bits hold it, and a 26-bit trial subtraction gives the borrow.
  // ---------------------------------------------------------------------------
  logic [25:0]       diff;
  logic              q_bit;
  logic [24:0]       rem_sel;
  logic [24:0]       rem_d;
  logic [25:0]       quo_d;
  logic signed [9:0] exp_d;

  always_comb begin
    diff    = {1'b0, rem_q} - {2'b00, 1'b1, fb};
    q_bit   = ~diff[25];
    rem_sel = q_bit ? diff[24:0] : rem_q;
    rem_d   = rem_sel << 1;
    quo_d   = {quo_q[24:0], q_bit};
    // Biased quotient exponent; range -126..380 fits a 10-bit signed value.
    exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
  end

  // ---------------------------------------------------------------------------
  // Normalisation, rounding and result selection (used in NORM)
  // The quotient lies in (0.5, 2): bit 25 is the integer bit when set,
  // otherwise the value is shifted left by one and the exponent drops by one.
  // ---------------------------------------------------------------------------
  logic [23:0]       mant;
  logic              guard, sticky, round_up;
  logic signed [9:0] exp_n, exp_f;
  logic [24:0]       mant_r;
  logic [22:0]       frac_f;
  logic [31:0]       res_d;
  logic              dz_d;

`ifndef FP_DIV_RNE_EN
  // Guard and sticky are not needed when truncating.
  logic unused_round;
  assign unused_round = guard ^ sticky;
`endif

  always_comb begin
    if (quo_q[25]) begin
      mant   = quo_q[25:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (|rem_q);
      exp_n  = exp_q;
    end else begin
      mant   = quo_q[24:1];
      guard  = quo_q[0];
      sticky = |rem_q;
      exp_n  = exp_q - 10'sd1;
    end

`ifdef FP_DIV_RNE_EN
    round_up = guard & (sticky | mant[0]);
`else
    round_up = 1'b0;
`endif

    mant_r = {1'b0, mant} + {24'd0, round_up};
    // A rounding carry makes the mantissa 10.000..0: the fraction becomes zero
    // and the exponent moves up by one.
    if (mant_r[24]) begin
      frac_f = mant_r[23:1];
      exp_f  = exp_n + 10'sd1;
    end else begin
      frac_f = mant_r[22:0];
      exp_f  = exp_n;
    end

    dz_d = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      res_d = 32'h7FC0_0000;
    end else if (a_inf) begin
      res_d = {sign, 8'hFF, 23'd0};
    end else if (b_inf) begin
      res_d = {sign, 31'd0};
    end else if (a_zero) begin
      res_d = {sign, 31'd0};
    end else if (b_zero) begin
      res_d = {sign, 8'hFF, 23'd0};
      dz_d  = 1'b1;
    end else if (exp_f >= 10'sd255) begin
      res_d = {sign, 8'hFF, 23'd0};
    end else if (exp_f <= 10'sd0) begin
      res_d = {sign, 31'd0};
    end else begin
      res_d = {sign, exp_f[7:0], frac_f};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // DIVIDE spends one cycle (cnt 0) loading the remainder and exponent, then
  // 26 cycles producing quotient bits; NORM then registers the result, which
  // places out_valid 28 edges after the accept edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      res_q   <= 32'd0;
      dz_q    <= 1'b0;
      cnt_q   <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= Operando_A;
            b_q     <= Operando_B;
            cnt_q   <= 5'd0;
            state_q <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (cnt_q == 5'd0) begin
            exp_q <= exp_d;
            rem_q <= {2'b01, fa};
            quo_q <= 26'd0;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
          end
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd26) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          res_q   <= res_d;
          dz_q    <= dz_d;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = valid_q;
  assign Resultado = res_q;
  assign Div_cero  = dz_q;

endmodule

// File: tb/tb_fp_divider.sv
// -----------------------------------------------------------------------------
// tb_fp_divider -- scoreboard bench for fp_divider
//   The driver pushes the expected response of each accepted operation into a
//   queue; a monitor pops and compares whenever out_valid rises. The reference
//   model divides with wide integer arithmetic in one shot.
// -----------------------------------------------------------------------------
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Operando_A;
  logic [31:0] Operando_B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Resultado;
  logic        Div_cero;

  always #5 clk = ~clk;

  fp_divider dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Operando_A (Operando_A),
    .Operando_B (Operando_B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Resultado  (Resultado),
    .Div_cero   (Div_cero)
  );

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          acc;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;
  bit   long_hold = 1'b0;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: quotient of the 24-bit significands scaled by 2^25, then
  // normalise, round and range-check.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic dz);
    logic   s;
    int     ea, eb, e;
    longint ma, mb, num, q, rm, mant;
    bit     g, st, a_z, b_z, a_i, b_i, a_n, b_n;
    s   = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    a_z = (ea == 0);
    b_z = (eb == 0);
    a_i = (ea == 255) && (a[22:0] == 0);
    b_i = (eb == 255) && (b[22:0] == 0);
    a_n = (ea == 255) && (a[22:0] != 0);
    b_n = (eb == 255) && (b[22:0] != 0);
    dz  = 1'b0;
    if (a_n || b_n || (a_z && b_z) || (a_i && b_i)) r = 32'h7FC00000;
    else if (a_i) r = {s, 8'hFF, 23'd0};
    else if (b_i) r = {s, 31'd0};
    else if (a_z) r = {s, 31'd0};
    else if (b_z) begin r = {s, 8'hFF, 23'd0}; dz = 1'b1; end
    else begin
      ma  = longint'({1'b1, a[22:0]});
      mb  = longint'({1'b1, b[22:0]});
      num = ma << 25;
      q   = num / mb;
      rm  = num % mb;
      e   = ea - eb + 127;
      if (q >= (longint'(1) << 25)) begin
        mant = q >> 2;
        g    = q[1];
        st   = q[0] || (rm != 0);
      end else begin
        mant = q >> 1;
        g    = q[0];
        st   = (rm != 0);
        e    = e - 1;
      end
`ifdef FP_DIV_RNE_EN
      if (g && (st || mant[0])) mant = mant + 1;
      if (mant == (longint'(1) << 24)) begin
        mant = longint'(1) << 23;
        e    = e + 1;
      end
`else
      if (g && st) mant = mant;  // truncation keeps the significand
`endif
      if (e >= 255)    r = {s, 8'hFF, 23'd0};
      else if (e <= 0) r = {s, 31'd0};
      else             r = {s, e[7:0], mant[22:0]};
    end
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Present one operation; junk with random in_valid is driven while busy
  // and must be ignored by the block.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        dz;
    exp_t        e;
    int          n = 0;
    while (!in_ready && n < 300) begin
      in_valid   = 1'($urandom_range(0, 1));
      Operando_A = $urandom;
      Operando_B = $urandom;
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual in_ready=0 required in_ready=1");
      in_valid = 1'b0;
      return;
    end
    ref_div(a, b, r, dz);
    Operando_A = a;
    Operando_B = b;
    in_valid   = 1'b1;
    e.res = r;
    e.dz  = dz;
    e.acc = edges + 1;
    e.a   = a;
    e.b   = b;
    sb.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() > 0 || out_valid || !in_ready) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual pending=%0d required pending=0", sb.size());
    end
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int          k;
    v = $urandom;
    k = int'($urandom_range(0, 15));
    case (k)
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      2: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      3: v[30:0] = 31'd0;
      4: v[30:23] = 8'hFE;
      5: v[30:23] = 8'h01;
      6: v[22:0] = 23'd0;
      7: v[22:0] = 23'h7FFFFF;
      default: v[30:23] = 8'($urandom_range(96, 160));
    endcase
    return v;
  endfunction

  // Monitor / scoreboard: samples on the falling edge, drives out_ready.
  initial begin
    bit          pv = 1'b0;
    bit          phs = 1'b0;
    int          hold = 0;
    logic [31:0] hres = 32'd0;
    logic        hdz = 1'b0;
    exp_t        e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv   = 1'b0;
        phs  = 1'b0;
        hold = 0;
      end else begin
        if (phs) begin
          chk("return_idle_valid", {31'd0, out_valid}, 32'd0);
          chk("return_idle_ready", {31'd0, in_ready}, 32'd1);
        end
        phs = 1'b0;
        if (out_valid) begin
          if (!pv) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL spurious_valid actual out_valid=1 required out_valid=0");
            end else begin
              e = sb.pop_front();
              $display("txn A=%h B=%h R=%h dz=%b lat=%0d", e.a, e.b, Resultado, Div_cero, edges - e.acc);
              chk("result", Resultado, e.res);
              chk("div_cero", {31'd0, Div_cero}, {31'd0, e.dz});
              chk("latency", edges - e.acc, 32'd28);
            end
            hres = Resultado;
            hdz  = Div_cero;
            hold = long_hold ? 5 : int'($urandom_range(0, 2));
            long_hold = 1'b0;
          end else begin
            chk("hold_result", Resultado, hres);
            chk("hold_dz", {31'd0, Div_cero}, {31'd0, hdz});
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
          end
          if (hold == 0) begin
            out_ready = 1'b1;
            phs = 1'b1;
          end else begin
            out_ready = 1'b0;
            hold--;
          end
        end else begin
          out_ready = 1'($urandom_range(0, 1));
          if (sb.size() > 0 && (edges - sb[0].acc) > 40) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout actual out_valid=0 required out_valid=1 A=%h B=%h", sb[0].a, sb[0].b);
            void'(sb.pop_front());
          end
        end
        pv = out_valid;
      end
    end
  end

  initial begin
    int acc;
    rst        = 1'b1;
    in_valid   = 1'b0;
    Operando_A = 32'd0;
    Operando_B = 32'd0;
    repeat (3) step();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", Resultado, 32'd0);
    chk("reset_div_cero", {31'd0, Div_cero}, 32'd0);
    rst = 1'b0;
    step();

    // Directed cases; the first one also stalls out_ready for 5 cycles.
    long_hold = 1'b1;
    issue(32'h40C00000, 32'h40000000);
    issue(32'h3F800000, 32'h40400000);
    issue(32'hBF800000, 32'h00000000);
    issue(32'h00000000, 32'h00000000);
    issue(32'h7F000000, 32'h3E800000);
    issue(32'h00800000, 32'h4B000000);
    issue(32'h7F800000, 32'h00000000);
    issue(32'h3F800000, 32'hFF800000);
    wait_drain();

    // Reset 10 edges after accept: the operation is discarded.
    issue(32'h3FC00000, 32'h3F800000);
    acc = sb[sb.size() - 1].acc;
    while (edges < acc + 9) step();
    rst = 1'b1;
    step();
    chk("midop_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("midop_rst_result", Resultado, 32'd0);
    chk("midop_rst_dz", {31'd0, Div_cero}, 32'd0);
    chk("midop_rst_ready", {31'd0, in_ready}, 32'd0);
    sb.delete();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    issue(32'h40490FDB, 32'h402DF854);
    chk("post_rst_accept_edge", sb[sb.size() - 1].acc, acc + 11);
    wait_drain();

    for (int i = 0; i < 40; i++) begin
      issue(rnd_op(), rnd_op());
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
